// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round controller (tick timing, mole picking, scoring)
// Optional MOLE_PENALTY_EN: a non-matching hit while a mole is up costs one point.
module mole_round_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int GAME_TICKS = 60,
  parameter int MOLE_TICKS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] hit,
  output logic [3:0] mole,
  output logic [7:0] score,
  output logic [6:0] time_left,
  output logic       playing,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, PICK, UP, OVER} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [25:0] r_tick_cnt;
  logic [7:0]  r_lfsr;
  logic [3:0]  r_mole_timer;
  logic [3:0]  w_timer_nxt;
  logic [1:0]  r_idx;
  logic [1:0]  w_idx_nxt;
  logic [1:0]  w_pick_idx;
  logic [7:0]  r_score;
  logic [7:0]  w_score_nxt;
  logic [6:0]  r_time_left;
  logic [6:0]  w_tl_nxt;
  logic [3:0]  r_mole;
  logic        r_playing;
  logic        r_game_over;
  logic        w_tick;
  logic        w_start_ok;
  logic        w_match;
  logic        w_final_tick;

  assign w_tick       = (r_tick_cnt == 26'(TICK_DIV - 1));
  assign w_start_ok   = start && ((r_state == IDLE) || (r_state == OVER));
  assign w_match      = hit[r_idx];
  assign w_final_tick = w_tick && (r_time_left == 7'd1);
  // Avoid showing the same hole twice in a row.
  assign w_pick_idx   = (r_lfsr[1:0] == r_idx) ? (r_lfsr[1:0] + 2'd1) : r_lfsr[1:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_start_ok || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 26'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lfsr <= 8'hA5;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_score_nxt = r_score;
    w_tl_nxt    = r_time_left;
    w_timer_nxt = r_mole_timer;
    w_idx_nxt   = r_idx;
    case (r_state)
      IDLE, OVER: begin
        if (start) begin
          w_state_nxt = PICK;
          w_score_nxt = 8'd0;
          w_tl_nxt    = 7'(GAME_TICKS);
        end
      end
      PICK: begin
        w_idx_nxt   = w_pick_idx;
        w_timer_nxt = 4'(MOLE_TICKS);
        w_state_nxt = UP;
      end
      UP: begin
        if (w_match) begin
          if (r_score != 8'hFF) w_score_nxt = r_score + 8'd1;
          w_state_nxt = PICK;
        end else begin
`ifdef MOLE_PENALTY_EN
          if ((hit != 4'b0) && (r_score != 8'd0)) w_score_nxt = r_score - 8'd1;
`endif
          if (w_tick && (r_mole_timer != 4'd0)) begin
            w_timer_nxt = r_mole_timer - 4'd1;
            if (r_mole_timer == 4'd1) w_state_nxt = PICK;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // The round clock runs through both PICK and UP and wins over mole transitions.
    if ((r_state == PICK) || (r_state == UP)) begin
      if (w_tick && (r_time_left != 7'd0)) w_tl_nxt = r_time_left - 7'd1;
      if (w_final_tick) w_state_nxt = OVER;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_score      <= '0;
      r_time_left  <= '0;
      r_mole_timer <= '0;
      r_idx        <= '0;
      r_mole       <= '0;
      r_playing    <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_score      <= w_score_nxt;
      r_time_left  <= w_tl_nxt;
      r_mole_timer <= w_timer_nxt;
      r_idx        <= w_idx_nxt;
      r_mole       <= (w_state_nxt == UP) ? (4'b0001 << w_idx_nxt) : 4'b0000;
      r_playing    <= (w_state_nxt == PICK) || (w_state_nxt == UP);
      r_game_over  <= (w_state_nxt == OVER);
    end
  end

  assign mole      = r_mole;
  assign score     = r_score;
  assign time_left = r_time_left;
  assign playing   = r_playing;
  assign game_over = r_game_over;

endmodule

// File: doc/mole_round_ctrl.md
MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clock cycles per game tick, legal range 2..2^26.
REQ-002 Parameter GAME_TICKS, default 60: round length in ticks, legal range 1..127.
REQ-003 Parameter MOLE_TICKS, default 2: ticks a mole stays up if not hit, legal range 1..15.
REQ-004 Port clock, input, 1: system clock, all logic on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: synchronous, already-debounced start request, sampled every cycle.
REQ-007 Port hit, input, 4: synchronous, already-debounced single-cycle button pulses, bit i means mole i was whacked.
REQ-008 Port mole, output, 4: one-hot visible mole, 0 when no mole is up.
REQ-009 Port score, output, 8: hits this round.
REQ-010 Port time_left, output, 7: ticks remaining in the round.
REQ-011 Port playing, output, 1: high in PICK or UP.
REQ-012 Port game_over, output, 1: high in OVER.

Function
REQ-013 The tick generator SHALL be a 26-bit counter counting 0..TICK_DIV-1 and raise internal tick for exactly one cycle when count==TICK_DIV-1, then wrap to 0.
REQ-014 The tick counter SHALL be cleared to 0 in the cycle start is accepted, so the first tick arrives TICK_DIV cycles after acceptance.
REQ-015 The FSM SHALL have states IDLE, PICK, UP, OVER; all outputs SHALL be registered.
REQ-016 IDLE/OVER + start: next state PICK, score<=0, time_left<=GAME_TICKS; start SHALL be ignored in PICK and UP.
REQ-017 PICK SHALL last exactly one cycle: mole index = lfsr[1:0], replaced by (lfsr[1:0]+1) mod 4 if equal to previous index; mole_timer<=MOLE_TICKS; next state UP.
REQ-018 The LFSR SHALL be 8 bits, polynomial x^8+x^6+x^5+x^4+1, advancing every cycle, never all-zero.
REQ-019 In UP, mole SHALL be the one-hot of the selected index; in all other states mole SHALL be 0.
REQ-020 In UP, hit bit matching the selected index: score<=score+1 saturating at 255, next state PICK.
REQ-021 In UP with no matching hit, each tick SHALL decrement mole_timer; when it reaches 0 the next state is PICK (miss, score unchanged).
REQ-022 In PICK and UP, each tick SHALL decrement time_left; the tick that makes time_left 0 SHALL move the FSM to OVER, overriding PICK/UP transitions.
REQ-023 Matching hit and final tick in the same cycle: score SHALL increment and next state SHALL be OVER.
REQ-024 Matching hit and mole-expiry tick in the same cycle: counted as a hit.
REQ-025 Matching and non-matching bits in one hit pulse: treated as a matching hit only.
REQ-026 In OVER, score and time_left (0) SHALL hold until the next accepted start.

Reset
REQ-027 On reset: state IDLE, mole=0, score=0, time_left=0, playing=0, game_over=0, tick counter=0, mole_timer=0, previous index=0, LFSR=8'hA5.
REQ-028 Reset asserted mid-round SHALL abort the round immediately, with no score retained.

Configuration
REQ-029 Macro MOLE_PENALTY_EN defined: in UP, a hit with no matching bit SHALL decrement score, saturating at 0, with no state change.
REQ-030 Macro MOLE_PENALTY_EN undefined: non-matching hits SHALL be ignored entirely.

Verification (TICK_DIV=4, GAME_TICKS=5, MOLE_TICKS=2)
REQ-031 Release reset, pulse start -> playing=1 one cycle later, mole one-hot two cycles later, time_left=5.
REQ-032 Matching hit while UP -> score 0->1 next cycle, mole=0 for one cycle (PICK), new mole index differs from the previous one.
REQ-033 No hits -> each mole held 8 cycles, time_left 5->0 over 20 cycles, then game_over=1, mole=0, score=0.
REQ-034 Matching hit in the same cycle as the final tick -> score increments and game_over=1 next cycle.
REQ-035 Non-matching hit at score=1: score becomes 0 with MOLE_PENALTY_EN defined, stays 1 without it; at score=0 it stays 0 either way.
REQ-036 Reset mid-round at score=3 -> all outputs 0 immediately; start while UP -> ignored, time_left unaffected.
